// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU: latches one instruction per run
// handshake and sequences bus select, A/G loads, ALU op and register write.
module cpu_control_fsm #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic [IDX_W-1:0]  wr_idx,
  output logic              wr_en,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [1:0]        bus_sel,
  output logic              a_load,
  output logic              g_load,
  output logic              alu_sub,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  localparam logic [IDX_W-1:0] OP_MV  = IDX_W'(0);
  localparam logic [IDX_W-1:0] OP_MVI = IDX_W'(1);
  localparam logic [IDX_W-1:0] OP_ADD = IDX_W'(2);
  localparam logic [IDX_W-1:0] OP_SUB = IDX_W'(3);

  localparam logic [1:0] BUS_REG = 2'b00;
  localparam logic [1:0] BUS_DIN = 2'b01;
  localparam logic [1:0] BUS_G   = 2'b10;

  state_t state, state_nx;

  // Only op/rx/ry are kept; the low nibble of the instruction word is don't-care.
  logic [3*IDX_W-1:0] ir;
  logic [IDX_W-1:0]   op, rx, ry;
  logic               unused_din;

  assign op = ir[3*IDX_W-1 -: IDX_W];
  assign rx = ir[2*IDX_W-1 -: IDX_W];
  assign ry = ir[IDX_W-1:0];
  assign unused_din = ^din[DATA_W-3*IDX_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && run)
        ir <= din[DATA_W-1 -: 3*IDX_W];
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    wr_idx   = '0;
    wr_en    = 1'b0;
    rd_idx   = '0;
    bus_sel  = BUS_REG;
    a_load   = 1'b0;
    g_load   = 1'b0;
    alu_sub  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run)
          state_nx = S_T1;
      end
      S_T1: begin
        busy = 1'b1;
        case (op)
          OP_MV: begin
            rd_idx = ry;
            wr_idx = rx;
            wr_en  = 1'b1;
            done   = 1'b1;
          end
          OP_MVI: begin
            bus_sel = BUS_DIN;
            wr_idx  = rx;
            wr_en   = 1'b1;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rd_idx   = rx;
            a_load   = 1'b1;
            state_nx = S_T2;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      // T2/T3 are only reachable for ADD/SUB; anything else falls back to idle.
      S_T2: begin
        busy = 1'b1;
        if (op == OP_ADD || op == OP_SUB) begin
          rd_idx   = ry;
          g_load   = 1'b1;
          alu_sub  = (op == OP_SUB);
          state_nx = S_T3;
        end
      end
      S_T3: begin
        busy    = 1'b1;
        bus_sel = BUS_G;
        wr_idx  = rx;
        wr_en   = 1'b1;
        done    = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: table of instructions with expected
// per-cycle output bundles, plus hand sequences for reset, run-while-busy and back-to-back.
module tb_cpu_control_fsm;

  typedef struct packed {
    logic [3:0] wr_idx;
    logic       wr_en;
    logic [3:0] rd_idx;
    logic [1:0] bus_sel;
    logic       a_load;
    logic       g_load;
    logic       alu_sub;
    logic       busy;
    logic       done;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [15:0]     instr;
    logic [15:0]     imm;
    int              n;
    outs_t [3:0]     exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        run = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  wr_idx, rd_idx;
  logic [1:0]  bus_sel;
  logic        wr_en, a_load, g_load, alu_sub, busy, done, illegal;

  outs_t act;
  outs_t expQ[$];
  vec_t  vecs[8];
  int    nv = 0;
  int    testsRun = 0;
  int    testsFailed = 0;

  cpu_control_fsm #(.IDX_W(4), .DATA_W(16)) dut (
    .clk(clk), .resetn(resetn), .run(run), .din(din),
    .wr_idx(wr_idx), .wr_en(wr_en), .rd_idx(rd_idx), .bus_sel(bus_sel),
    .a_load(a_load), .g_load(g_load), .alu_sub(alu_sub),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb act = {wr_idx, wr_en, rd_idx, bus_sel, a_load, g_load, alu_sub, busy, done, illegal};

  function automatic outs_t ob(input logic [3:0] wi, input logic we, input logic [3:0] ri,
                               input logic [1:0] bs, input logic al, input logic gl,
                               input logic su, input logic bz, input logic dn, input logic il);
    outs_t o;
    o.wr_idx = wi; o.wr_en = we; o.rd_idx = ri; o.bus_sel = bs;
    o.a_load = al; o.g_load = gl; o.alu_sub = su;
    o.busy = bz; o.done = dn; o.illegal = il;
    return o;
  endfunction

  task automatic addVec(input logic [15:0] ins, input logic [15:0] imm, input int n,
                        input outs_t e0, input outs_t e1, input outs_t e2, input outs_t e3);
    vecs[nv].instr  = ins;
    vecs[nv].imm    = imm;
    vecs[nv].n      = n;
    vecs[nv].exp[0] = e0;
    vecs[nv].exp[1] = e1;
    vecs[nv].exp[2] = e2;
    vecs[nv].exp[3] = e3;
    nv++;
  endtask

  task automatic checkOutput(input string nm);
    outs_t e;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", nm, act);
    end else begin
      e = expQ.pop_front();
      if (act !== e) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h want %h (wr_idx wr_en rd_idx bus_sel a g sub busy done ill)",
                 nm, act, e);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] d, input outs_t e, input string nm);
    run = r;
    din = d;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(nm);
  endtask

  outs_t z, mv7, add12_t1, add12_t2, add12_t3;

  initial begin
    z        = '0;
    mv7      = ob(4'd7, 1, 4'd0, 2'b00, 0, 0, 0, 1, 1, 0);
    add12_t1 = ob(4'd0, 0, 4'd1, 2'b00, 1, 0, 0, 1, 0, 0);
    add12_t2 = ob(4'd0, 0, 4'd2, 2'b00, 0, 1, 0, 1, 0, 0);
    add12_t3 = ob(4'd1, 1, 4'd0, 2'b10, 0, 0, 0, 1, 1, 0);

    addVec(16'h1500, 16'h00AB, 2, ob(4'd5, 1, 4'd0, 2'b01, 0, 0, 0, 1, 1, 0), z, z, z);
    addVec(16'h2120, 16'h0000, 4, add12_t1, add12_t2, add12_t3, z);
    addVec(16'h0390, 16'h0000, 2, ob(4'd3, 1, 4'd9, 2'b00, 0, 0, 0, 1, 1, 0), z, z, z);
    addVec(16'h2330, 16'h0000, 4, ob(4'd0, 0, 4'd3, 2'b00, 1, 0, 0, 1, 0, 0),
           ob(4'd0, 0, 4'd3, 2'b00, 0, 1, 0, 1, 0, 0),
           ob(4'd3, 1, 4'd0, 2'b10, 0, 0, 0, 1, 1, 0), z);
    addVec(16'hF000, 16'h0000, 2, ob(4'd0, 0, 4'd0, 2'b00, 0, 0, 0, 1, 1, 1), z, z, z);
    addVec(16'h4123, 16'h0000, 2, ob(4'd0, 0, 4'd0, 2'b00, 0, 0, 0, 1, 1, 1), z, z, z);
    addVec(16'h36A5, 16'h0000, 4, ob(4'd0, 0, 4'd6, 2'b00, 1, 0, 0, 1, 0, 0),
           ob(4'd0, 0, 4'd10, 2'b00, 0, 1, 1, 1, 0, 0),
           ob(4'd6, 1, 4'd0, 2'b10, 0, 0, 0, 1, 1, 0), z);
    addVec(16'h1FC7, 16'hFFFF, 2, ob(4'd15, 1, 4'd0, 2'b01, 0, 0, 0, 1, 1, 0), z, z, z);

    // Reset held with run asserted: nothing may start.
    run = 1'b1;
    din = 16'h2120;
    resetn = 1'b0;
    #1;
    expQ.push_back(z);
    checkOutput("reset_async");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'h2120, z, $sformatf("reset_hold%0d", i));
    resetn = 1'b1;
    applyStimulus(1'b0, 16'h0000, z, "post_reset_idle");

    for (int i = 0; i < nv; i++)
      for (int k = 0; k < vecs[i].n; k++)
        applyStimulus(k == 0, (k == 0) ? vecs[i].instr : vecs[i].imm, vecs[i].exp[k],
                      $sformatf("vec%0d_%h_step%0d", i, vecs[i].instr, k));

    // SUB r4,r4 with run pulsed during T2: must not start another instruction.
    applyStimulus(1'b1, 16'h3440, ob(4'd0, 0, 4'd4, 2'b00, 1, 0, 0, 1, 0, 0), "sub_t1");
    applyStimulus(1'b0, 16'h0000, ob(4'd0, 0, 4'd4, 2'b00, 0, 1, 1, 1, 0, 0), "sub_t2");
    applyStimulus(1'b1, 16'h2120, ob(4'd4, 1, 4'd0, 2'b10, 0, 0, 0, 1, 1, 0), "sub_t3_run_ignored");
    applyStimulus(1'b0, 16'h0000, z, "sub_idle");
    applyStimulus(1'b0, 16'h0000, z, "sub_no_extra");

    // run held high: one idle cycle between back-to-back instructions.
    applyStimulus(1'b1, 16'h0700, mv7, "b2b_first");
    applyStimulus(1'b1, 16'h0700, z, "b2b_gap");
    applyStimulus(1'b1, 16'h0700, mv7, "b2b_second");
    applyStimulus(1'b0, 16'h0000, z, "b2b_idle");

    // ADD aborted by reset in T2, then a normal MV.
    applyStimulus(1'b1, 16'h2120, add12_t1, "abort_t1");
    applyStimulus(1'b0, 16'h0000, add12_t2, "abort_t2");
    #2;
    resetn = 1'b0;
    #1;
    expQ.push_back(z);
    checkOutput("abort_async");
    applyStimulus(1'b0, 16'h0000, z, "abort_hold");
    resetn = 1'b1;
    applyStimulus(1'b0, 16'h0000, z, "abort_released_idle");
    applyStimulus(1'b0, 16'h0000, z, "abort_no_late_write");
    applyStimulus(1'b1, 16'h0700, mv7, "mv_after_abort");
    applyStimulus(1'b0, 16'h0000, z, "mv_after_abort_idle");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
